// File: rtl/bsg_wormhole_concentrator_out_buffered.sv
// Wormhole deconcentrator: one concentrated input link is steered by header
// cid (minus cid_base_p) to one of num_out_p buffered output links.
// Ports: clk_i, reset_n_i (async, active-low);
//   concentrated_link_{v_i,data_i,ready_and_rev_o}: input, ready-and;
//   links_{v_o,data_o,ready_and_rev_i}: per-output links;
//   drop_count_o / drop_v_o: saturating count and pulse for dropped packets.
module bsg_wormhole_concentrator_out_buffered #(
  parameter int flit_width_p   = 16,
  parameter int len_width_p    = 4,
  parameter int cid_width_p    = 4,
  parameter int cord_width_p   = 4,
  parameter int num_out_p      = 4,
  parameter int out_fifo_els_p = 2,
  parameter int cid_base_p     = 0,
  parameter int drop_bad_cid_p = 1
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic                              concentrated_link_v_i,
  input  logic [flit_width_p-1:0]           concentrated_link_data_i,
  output logic                              concentrated_link_ready_and_rev_o,
  output logic [num_out_p-1:0]              links_v_o,
  output logic [num_out_p*flit_width_p-1:0] links_data_o,
  input  logic [num_out_p-1:0]              links_ready_and_rev_i,
  output logic [15:0]                       drop_count_o,
  output logic                              drop_v_o
);

  localparam int dw = (num_out_p > 1) ? $clog2(num_out_p) : 1;

  typedef enum logic [1:0] {HEADER, BODY, DROP} state_e;

  // FIFO num_out_p is the two-entry input stage; 0..num_out_p-1 are outputs.
  logic [num_out_p:0]    f_push, f_pop, f_full, f_v;
  logic [flit_width_p-1:0] f_data [num_out_p+1];

  state_e                 state_r, state_n;
  logic [len_width_p-1:0] cnt_r;
  logic [dw-1:0]          dest_r, sel;
  logic [15:0]            drop_cnt_r;
  logic                   drop_v_r, ready_r;

  logic [flit_width_p-1:0] head;
  logic                    head_v;
  logic [len_width_p-1:0]  hdr_len;
  logic [cid_width_p-1:0]  hdr_cid;
  logic [cid_width_p:0]    idx;
  logic                    in_range, room;
  logic [num_out_p-1:0]    oh;
  logic steer_pop, steer_push, load, dec, drop;

  assign head    = f_data[num_out_p];
  assign head_v  = f_v[num_out_p];
  assign hdr_len = head[cord_width_p +: len_width_p];
  assign hdr_cid = head[cord_width_p+len_width_p +: cid_width_p];

  // Borrow out of the extra bit flags cid < cid_base_p.
  assign idx = {1'b0, hdr_cid} - (cid_width_p+1)'(cid_base_p);
  assign in_range = ~idx[cid_width_p]
                  && (idx < (cid_width_p+1)'(num_out_p));

  assign sel = (state_r == HEADER) ? idx[dw-1:0] : dest_r;

  always_comb begin
    oh = '0;
    for (int i = 0; i < num_out_p; i++) oh[i] = (sel == dw'(i));
  end

  assign room = |(oh & ~f_full[num_out_p-1:0]);

  assign concentrated_link_ready_and_rev_o = ready_r & ~f_full[num_out_p];

  assign f_push = {concentrated_link_v_i & concentrated_link_ready_and_rev_o,
                   oh & {num_out_p{steer_push}}};
  assign f_pop  = {steer_pop, links_ready_and_rev_i};

  for (genvar g = 0; g <= num_out_p; g++) begin : fifo
    localparam int els = (g == num_out_p) ? 2 : out_fifo_els_p;
    localparam int pw  = $clog2(els);
    localparam int cw  = $clog2(els + 1);
    logic [flit_width_p-1:0] mem [els];
    logic [pw-1:0] rp, wp;
    logic [cw-1:0] n;
    logic wr, rd;
    logic [flit_width_p-1:0] din;

    assign din       = (g == num_out_p) ? concentrated_link_data_i : head;
    assign f_full[g] = (n == cw'(els));
    assign f_v[g]    = (n != '0);
    assign f_data[g] = mem[rp];
    // Full blocks the push even when a pop happens in the same cycle.
    assign wr = f_push[g] & ~f_full[g];
    assign rd = f_pop[g] & f_v[g];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        rp <= '0;
        wp <= '0;
        n  <= '0;
      end else begin
        if (wr) wp <= (wp == pw'(els-1)) ? '0 : wp + pw'(1);
        if (rd) rp <= (rp == pw'(els-1)) ? '0 : rp + pw'(1);
        unique case ({wr, rd})
          2'b10:   n <= n + cw'(1);
          2'b01:   n <= n - cw'(1);
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk_i) begin
      if (wr) mem[wp] <= din;
    end
  end

  for (genvar i = 0; i < num_out_p; i++) begin : link
    assign links_v_o[i] = f_v[i];
    assign links_data_o[i*flit_width_p +: flit_width_p] = f_data[i];
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= HEADER;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      HEADER:
        if (load && hdr_len != '0) state_n = drop ? DROP : BODY;
      BODY, DROP:
        if (dec && cnt_r == len_width_p'(1)) state_n = HEADER;
      default: state_n = HEADER;
    endcase
  end

  always_comb begin
    steer_pop  = 1'b0;
    steer_push = 1'b0;
    load       = 1'b0;
    dec        = 1'b0;
    drop       = 1'b0;
    unique case (state_r)
      HEADER:
        if (head_v) begin
          if (in_range) begin
            if (room) begin
              steer_pop  = 1'b1;
              steer_push = 1'b1;
              load       = 1'b1;
            end
          end else if (drop_bad_cid_p != 0) begin
            steer_pop = 1'b1;
            load      = 1'b1;
            drop      = 1'b1;
          end
        end
      BODY:
        if (head_v && room) begin
          steer_pop  = 1'b1;
          steer_push = 1'b1;
          dec        = 1'b1;
        end
      DROP:
        if (head_v) begin
          steer_pop = 1'b1;
          dec       = 1'b1;
        end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_r      <= '0;
      dest_r     <= '0;
      drop_cnt_r <= '0;
      drop_v_r   <= 1'b0;
      ready_r    <= 1'b0;
    end else begin
      ready_r  <= 1'b1;
      drop_v_r <= drop;
      if (load) begin
        cnt_r  <= hdr_len;
        dest_r <= idx[dw-1:0];
      end else if (dec) begin
        cnt_r <= cnt_r - len_width_p'(1);
      end
      if (drop && drop_cnt_r != '1) drop_cnt_r <= drop_cnt_r + 16'd1;
    end
  end

  assign drop_count_o = drop_cnt_r;
  assign drop_v_o     = drop_v_r;

  a_params: assert property (@(posedge clk_i)
    (num_out_p <= (1 << cid_width_p))
    && (flit_width_p >= cord_width_p + len_width_p + cid_width_p));

  a_bad_cid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(state_r == HEADER && head_v && !in_range && drop_bad_cid_p == 0));

endmodule

// File: tb/tb_bsg_wormhole_concentrator_out_buffered.sv
// Directed bench for bsg_wormhole_concentrator_out_buffered.
// u0 uses cid base 0, u1 uses cid base 4; shared clock and reset.
module tb_bsg_wormhole_concentrator_out_buffered;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cv   [2];
  logic [15:0] cd   [2];
  logic        rdy  [2];
  logic [3:0]  lv   [2];
  logic [63:0] ld   [2];
  logic [3:0]  lr   [2];
  logic [15:0] dcnt [2];
  logic        dv   [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [15:0] exp_q [2][4][$];
  int rx [2][4];
  int first_v [2][4];
  int hdr_cyc [2];
  int stalls [2];
  int drops [2];

  bsg_wormhole_concentrator_out_buffered #(
    .flit_width_p(16), .len_width_p(4), .cid_width_p(4),
    .cord_width_p(4), .num_out_p(4), .out_fifo_els_p(2),
    .cid_base_p(0), .drop_bad_cid_p(1)
  ) u0 (
    .clk_i(clk), .reset_n_i(rst_n),
    .concentrated_link_v_i(cv[0]),
    .concentrated_link_data_i(cd[0]),
    .concentrated_link_ready_and_rev_o(rdy[0]),
    .links_v_o(lv[0]), .links_data_o(ld[0]),
    .links_ready_and_rev_i(lr[0]),
    .drop_count_o(dcnt[0]), .drop_v_o(dv[0])
  );

  bsg_wormhole_concentrator_out_buffered #(
    .flit_width_p(16), .len_width_p(4), .cid_width_p(4),
    .cord_width_p(4), .num_out_p(4), .out_fifo_els_p(2),
    .cid_base_p(4), .drop_bad_cid_p(1)
  ) u1 (
    .clk_i(clk), .reset_n_i(rst_n),
    .concentrated_link_v_i(cv[1]),
    .concentrated_link_data_i(cd[1]),
    .concentrated_link_ready_and_rev_o(rdy[1]),
    .links_v_o(lv[1]), .links_data_o(ld[1]),
    .links_ready_and_rev_i(lr[1]),
    .drop_count_o(dcnt[1]), .drop_v_o(dv[1])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Outputs settle after posedge; a valid&ready seen at negedge pops next edge.
  always @(negedge clk) begin
    logic [31:0] e;
    for (int k = 0; k < 2; k++) begin
      if (dv[k]) drops[k]++;
      for (int i = 0; i < 4; i++) begin
        if (lv[k][i] && first_v[k][i] < 0) first_v[k][i] = cyc;
        if (lv[k][i] && lr[k][i]) begin
          rx[k][i]++;
          if (exp_q[k][i].size() != 0) e = 32'(exp_q[k][i].pop_front());
          else e = 32'hDEAD_BEEF;
          chk($sformatf("u%0d_link%0d_data", k, i), 32'(ld[k][i*16 +: 16]), e);
        end
      end
    end
  end

  task automatic clear_stats();
    for (int k = 0; k < 2; k++) begin
      stalls[k] = 0;
      drops[k] = 0;
      for (int i = 0; i < 4; i++) begin
        rx[k][i] = 0;
        first_v[k][i] = -1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Header: {tag, cid, len, cord=5}; body j: {tag, j}. link<0 means dropped.
  task automatic send_pkt(input int k, input int cid, input int len,
                          input int link, input logic [3:0] tg);
    logic [15:0] f;
    int n;
    for (int j = 0; j <= len; j++) begin
      f = (j == 0) ? {tg, 4'(cid), 4'(len), 4'h5} : {tg, 12'(j)};
      if (link >= 0) exp_q[k][link].push_back(f);
      cv[k] = 1'b1;
      cd[k] = f;
      n = 0;
      @(negedge clk);
      while (!rdy[k] && n < 200) begin
        n++;
        stalls[k]++;
        @(negedge clk);
      end
      if (n >= 200) chk("send_timeout", n, 0);
      if (j == 0) hdr_cyc[k] = cyc;
      @(posedge clk);
      #1;
    end
    cv[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      cv[k] = 1'b0;
      cd[k] = '0;
      lr[k] = 4'hF;
    end
    clear_stats();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_lv0", lv[0], 0);
    chk("rst_rdy0", rdy[0], 0);
    chk("rst_dcnt1", dcnt[1], 0);
    chk("rst_dv1", dv[1], 0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rdy_after_rst", rdy[0], 1);

    // single packet, cid 2, len 3
    clear_stats();
    send_pkt(0, 2, 3, 2, 4'h1);
    idle(8);
    chk("t1_latency", first_v[0][2] - hdr_cyc[0], 2);
    chk("t1_rx2", rx[0][2], 4);
    chk("t1_rx_other", rx[0][0] + rx[0][1] + rx[0][3], 0);
    chk("t1_v_other", first_v[0][0] & first_v[0][1] & first_v[0][3], -1);
    chk("t1_q2", exp_q[0][2].size(), 0);

    // back-to-back packets, no bubbles
    clear_stats();
    send_pkt(0, 0, 0, 0, 4'h2);
    send_pkt(0, 1, 1, 1, 4'h3);
    send_pkt(0, 0, 2, 0, 4'h4);
    idle(8);
    chk("t2_stalls", stalls[0], 0);
    chk("t2_rx0", rx[0][0], 4);
    chk("t2_rx1", rx[0][1], 2);
    chk("t2_q0", exp_q[0][0].size(), 0);
    chk("t2_q1", exp_q[0][1].size(), 0);

    // output isolation: link 3 held, link 1 flows
    clear_stats();
    lr[0][3] = 1'b0;
    send_pkt(0, 3, 1, 3, 4'h5);
    send_pkt(0, 1, 2, 1, 4'h6);
    idle(8);
    chk("t3_rx1", rx[0][1], 3);
    chk("t3_rx3", rx[0][3], 0);
    chk("t3_v3", lv[0][3], 1);
    chk("t3_stalls", stalls[0], 0);

    // head-of-line stall on full FIFO 3, then release
    clear_stats();
    fork
      send_pkt(0, 3, 3, 3, 4'h7);
      begin
        repeat (6) @(posedge clk);
        #1;
        chk("t4_rdy_low", rdy[0], 0);
        chk("t4_rx3_held", rx[0][3], 0);
        lr[0][3] = 1'b1;
      end
    join
    idle(8);
    chk("t4_stalled", stalls[0] > 0, 1);
    chk("t4_rx3", rx[0][3], 6);
    chk("t4_q3", exp_q[0][3].size(), 0);

    // bad cid drops on u1 (base 4)
    clear_stats();
    send_pkt(1, 2, 2, -1, 4'h8);
    send_pkt(1, 9, 0, -1, 4'h9);
    send_pkt(1, 5, 1, 1, 4'hA);
    idle(8);
    chk("t5_drop_pulses", drops[1], 2);
    chk("t5_drop_count", dcnt[1], 2);
    chk("t5_rx1", rx[1][1], 2);
    chk("t5_rx_other", rx[1][0] + rx[1][2] + rx[1][3], 0);
    chk("t5_q1", exp_q[1][1].size(), 0);

    // async reset in the middle of a body
    clear_stats();
    lr[0][0] = 1'b0;
    cv[0] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      cd[0] = (j == 0) ? 16'hB055 : {4'hB, 12'(j)};
      @(posedge clk);
      #1;
    end
    chk("t6_pre_v0", lv[0][0], 1);
    #2;
    rst_n = 1'b0;
    cv[0] = 1'b0;
    #1;
    chk("t6_rst_lv", lv[0], 0);
    chk("t6_rst_rdy", rdy[0], 0);
    chk("t6_rst_dcnt1", dcnt[1], 0);
    lr[0][0] = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_pkt(0, 0, 1, 0, 4'hC);
    idle(8);
    chk("t6_rx0", rx[0][0], 2);
    chk("t6_q0", exp_q[0][0].size(), 0);
    chk("t6_dcnt0", dcnt[0], 0);
    chk("t6_dcnt1", dcnt[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
